// File: rtl/shift_arbiter_pkg.sv
// shift_arbiter_pkg: shift encodings, command struct and reference shift function
//   Exports SH_LEFT/SH_RIGHT (lr), SH_LOGIC/SH_ARITH (al), cmd_t and shift_ref().
package shift_arbiter_pkg;
  localparam logic SH_LEFT  = 1'b1;
  localparam logic SH_RIGHT = 1'b0;
  localparam logic SH_LOGIC = 1'b0;
  localparam logic SH_ARITH = 1'b1;
  localparam int CMD_W   = 8;
  localparam int CMD_SHW = 3;
  typedef struct packed {
    logic [CMD_W-1:0]   din;
    logic [CMD_SHW-1:0] shamt;
    logic               lr;
    logic               al;
  } cmd_t;
  function automatic logic [CMD_W-1:0] shift_ref(input cmd_t c);
    if (c.lr == SH_LEFT) return c.din << c.shamt;
    if (c.al == SH_ARITH) return $unsigned($signed(c.din) >>> c.shamt);
    return c.din >> c.shamt;
  endfunction
endpackage

// File: rtl/shift_arbiter_barrel_shifter.sv
// barrel_shifter: combinational log2(WIDTH)-stage left/right logical/arithmetic shifter
//   din/shamt/lr/al in, dout out; stage g shifts by 2**g when shamt[g] is set.
module barrel_shifter
  import shift_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  input  logic             lr,
  input  logic             al,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] w_st [SHW+1];
  logic             w_fill;
  // Sign fill only matters for right shifts; left stages always insert zeros.
  assign w_fill  = (al == SH_ARITH) & din[WIDTH-1];
  assign w_st[0] = din;
  for (genvar g = 0; g < SHW; g++) begin : g_stage
    localparam int S = 1 << g;
    assign w_st[g+1] = !shamt[g] ? w_st[g] :
                       (lr == SH_LEFT) ? {w_st[g][WIDTH-S-1:0], {S{1'b0}}} :
                       {{S{w_fill}}, w_st[g][WIDTH-1:S]};
  end
  assign dout = w_st[SHW];
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of one barrel shifter between two requesters
//   clk/rst (async, active-high); reqN_valid/ready/din/shamt/lr/al per requester;
//   out_valid/out_ready/out_dout/out_id registered result stage.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   SHW       = 3,
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_din,
  input  logic [SHW-1:0]   req0_shamt,
  input  logic             req0_lr,
  input  logic             req0_al,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_din,
  input  logic [SHW-1:0]   req1_shamt,
  input  logic             req1_lr,
  input  logic             req1_al,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_dout,
  output logic             out_id
);
  logic             r_prio, r_valid, r_id;
  logic [WIDTH-1:0] r_dout;
  logic             w_pipe_ready, w_any, w_gnt, w_xfer;
  logic [WIDTH-1:0] w_din, w_sh;
  logic [SHW-1:0]   w_shamt;
  logic             w_lr, w_al;
  assign w_pipe_ready = !r_valid | out_ready;
  assign w_any        = req0_valid | req1_valid;
  // Single requester wins outright; a tie goes to the priority holder.
  assign w_gnt        = (req0_valid & req1_valid) ? r_prio : req1_valid;
  assign w_xfer       = w_any & w_pipe_ready & !rst;
  assign req0_ready   = w_pipe_ready & w_any & !w_gnt & !rst;
  assign req1_ready   = w_pipe_ready & w_any & w_gnt & !rst;
  assign w_din        = w_gnt ? req1_din : req0_din;
  assign w_shamt      = w_gnt ? req1_shamt : req0_shamt;
  assign w_lr         = w_gnt ? req1_lr : req0_lr;
  assign w_al         = w_gnt ? req1_al : req0_al;
  barrel_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .din  (w_din),
    .shamt(w_shamt),
    .lr   (w_lr),
    .al   (w_al),
    .dout (w_sh)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_dout  <= '0;
      r_id    <= 1'b0;
      r_prio  <= PRIO_INIT;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_dout  <= w_sh;
      r_id    <= w_gnt;
      r_prio  <= ~w_gnt;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign out_valid = r_valid;
  assign out_dout  = r_dout;
  assign out_id    = r_id;
endmodule
